usbf_ssram_arb: RTL and testbench

Two-port arbiter between the internal DMA engine and the Wishbone slave path, sharing the single-port synchronous buffer SSRAM. It produces the single-cycle `mack` grant that the DMA engine samples, and returns read data one cycle after the access. It also gives host register-bus accesses a bounded-latency path through a starvation counter. It sits between the DMA engine / Wishbone interface and the SSRAM macro.

---
 rtl/usbf_ssram_arb_if.sv | 46 ++++
 rtl/usbf_ssram_arb.sv | 76 +++++++
 tb/tb_usbf_ssram_arb.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/usbf_ssram_arb_if.sv
// Bus bundle for the buffer SSRAM arbiter: DMA engine port (m*), Wishbone slave
// port (w*) and the SSRAM macro port (sram_*).
//   slave  modport: the arbiter side.
//   master modport: the requesters / SSRAM side that drives the arbiter inputs.
interface usbf_ssram_arb_if #(
    parameter int unsigned SSRAM_HADR = 14
);
    // DMA engine
    logic [SSRAM_HADR:0] madr;
    logic [31:0]         mdout;
    logic [31:0]         mdin;
    logic                mwe;
    logic                mreq;
    logic                mack;
    // Wishbone slave path
    logic [SSRAM_HADR:0] wadr;
    logic [31:0]         wdin;
    logic [31:0]         wdout;
    logic                wwe;
    logic                wreq;
    logic                wack;
    // SSRAM macro
    logic [SSRAM_HADR:0] sram_adr;
    logic [31:0]         sram_dout;
    logic [31:0]         sram_din;
    logic                sram_re;
    logic                sram_we;

    modport slave (
        input  madr, mdout, mwe, mreq,
        output mdin, mack,
        input  wadr, wdin, wwe, wreq,
        output wdout, wack,
        output sram_adr, sram_dout, sram_re, sram_we,
        input  sram_din
    );

    modport master (
        output madr, mdout, mwe, mreq,
        input  mdin, mack,
        output wadr, wdin, wwe, wreq,
        input  wdout, wack,
        input  sram_adr, sram_dout, sram_re, sram_we,
        output sram_din
    );
endinterface

// File: rtl/usbf_ssram_arb.sv
// Arbiter between the DMA engine and the Wishbone slave path for the single-port
// buffer SSRAM. DMA has priority; a Wishbone request waiting WB_MAX_WAIT cycles
// overrides it. DMA gets a combinational one-cycle grant (mack); Wishbone gets a
// registered one-cycle acknowledge (wack) the cycle after its access.
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - usbf_ssram_arb_if.slave: DMA (madr/mdout/mdin/mwe/mreq/mack),
//          Wishbone (wadr/wdin/wdout/wwe/wreq/wack),
//          SSRAM (sram_adr/sram_dout/sram_din/sram_re/sram_we)
module usbf_ssram_arb #(
    parameter int unsigned SSRAM_HADR  = 14,
    parameter int unsigned WB_MAX_WAIT = 4    // legal 1..15
) (
    input  logic            clk,
    input  logic            rst,
    usbf_ssram_arb_if.slave bus
);

    localparam logic [3:0] MaxWait = 4'(WB_MAX_WAIT);

    typedef enum logic {StIdle, StWbAck} state_e;

    state_e              state_q, state_d;
    logic [3:0]          wb_wait_q, wb_wait_d;
    logic [31:0]         wdout_q;
    logic                gnt_w, gnt_m;
    logic [SSRAM_HADR:0] adr_mux;

    // Grant, next-state and starvation counter
    always_comb begin
        gnt_w     = bus.wreq && (state_q == StIdle) && (!bus.mreq || (wb_wait_q == MaxWait));
        gnt_m     = bus.mreq && !gnt_w;
        state_d   = state_q;
        wb_wait_d = wb_wait_q;

        unique case (state_q)
            StIdle:  if (gnt_w) state_d = StWbAck;
            StWbAck: state_d = StIdle;   // no Wishbone grant here: wreq is still high
            default: state_d = StIdle;
        endcase

        if (!bus.wreq || gnt_w) begin
            wb_wait_d = 4'd0;
        end else if ((state_q == StIdle) && (wb_wait_q != MaxWait)) begin
            wb_wait_d = wb_wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            wb_wait_q <= 4'd0;
            wdout_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            wb_wait_q <= wb_wait_d;
            // Read word of the access granted last cycle
            if (state_q == StWbAck) wdout_q <= bus.sram_din;
        end
    end

    assign adr_mux       = gnt_w ? bus.wadr : bus.madr;
    assign bus.sram_adr  = adr_mux;
    assign bus.sram_dout = gnt_w ? bus.wdin : bus.mdout;

    // Strobes gated by rst so nothing reaches the SSRAM while reset is asserted
    assign bus.sram_we = rst & ((gnt_m & bus.mwe) | (gnt_w & bus.wwe));
    assign bus.sram_re = rst & ((gnt_m & ~bus.mwe) | (gnt_w & ~bus.wwe));

    assign bus.mack  = gnt_m & rst;
    assign bus.mdin  = bus.sram_din;
    assign bus.wack  = (state_q == StWbAck);
    assign bus.wdout = wdout_q;

endmodule

// File: tb/tb_usbf_ssram_arb.sv
module tb_usbf_ssram_arb;

    localparam int unsigned Hadr = 14;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] mem [0:(2**(Hadr+1))-1];

    usbf_ssram_arb_if #(.SSRAM_HADR(Hadr)) bus ();

    usbf_ssram_arb #(
        .SSRAM_HADR (Hadr),
        .WB_MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Synchronous SSRAM model: read data appears the cycle after the address
    always @(posedge clk) begin
        if (bus.sram_we) mem[bus.sram_adr] <= bus.sram_dout;
        if (bus.sram_re) bus.sram_din <= mem[bus.sram_adr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive point: just after the active edge. Sample point: falling edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // mreq held high, wreq raised together: grant must come at cycle 4
    task automatic starve(input string tag);
        bus.mreq = 1'b1; bus.mwe = 1'b0; bus.madr = 15'h0010;
        bus.wreq = 1'b1; bus.wwe = 1'b0; bus.wadr = 15'h0200;
        for (int i = 0; i < 4; i++) begin
            mid();
            check({tag, "_mack_early"}, {31'd0, bus.mack}, 32'd1);
            check({tag, "_adr_early"}, 32'(bus.sram_adr), 32'h0010);
            cyc();
        end
        mid();
        check({tag, "_mack_c4"}, {31'd0, bus.mack}, 32'd0);
        check({tag, "_re_c4"}, {31'd0, bus.sram_re}, 32'd1);
        check({tag, "_adr_c4"}, 32'(bus.sram_adr), 32'h0200);
        check({tag, "_wack_c4"}, {31'd0, bus.wack}, 32'd0);
        cyc();
        mid();
        check({tag, "_wack_c5"}, {31'd0, bus.wack}, 32'd1);
        check({tag, "_mack_c5"}, {31'd0, bus.mack}, 32'd1);
        cyc();
        bus.mreq = 1'b0; bus.wreq = 1'b0;
        mid();
        check({tag, "_wack_c6"}, {31'd0, bus.wack}, 32'd0);
        check({tag, "_wdout"}, bus.wdout, 32'h12345678);
    endtask

    initial begin
        for (int i = 0; i < 2**(Hadr+1); i++) mem[i] = 32'd0;
        mem[16] = 32'hDEADBEEF;

        // Reset held with both requests high
        rst = 1'b0;
        bus.madr = '0; bus.mdout = '0; bus.mwe = 1'b0; bus.mreq = 1'b1;
        bus.wadr = '0; bus.wdin = '0;  bus.wwe = 1'b0; bus.wreq = 1'b1;
        mid();
        check("rst_mack", {31'd0, bus.mack}, 32'd0);
        check("rst_we", {31'd0, bus.sram_we}, 32'd0);
        check("rst_re", {31'd0, bus.sram_re}, 32'd0);
        check("rst_wack", {31'd0, bus.wack}, 32'd0);
        check("rst_wdout", bus.wdout, 32'd0);
        cyc();
        mid();
        check("rst_wack2", {31'd0, bus.wack}, 32'd0);
        cyc();
        rst = 1'b1;
        mid();
        check("rel_mack", {31'd0, bus.mack}, 32'd1);
        check("rel_re", {31'd0, bus.sram_re}, 32'd1);
        cyc();
        bus.mreq = 1'b0; bus.wreq = 1'b0;
        mid();

        // DMA read
        cyc();
        bus.mreq = 1'b1; bus.mwe = 1'b0; bus.madr = 15'h0010;
        mid();
        check("dma_mack", {31'd0, bus.mack}, 32'd1);
        check("dma_re", {31'd0, bus.sram_re}, 32'd1);
        check("dma_adr", 32'(bus.sram_adr), 32'h0010);
        cyc();
        bus.mreq = 1'b0;
        mid();
        check("dma_mdin", bus.mdin, 32'hDEADBEEF);
        check("dma_mack_off", {31'd0, bus.mack}, 32'd0);

        // Wishbone write
        cyc();
        bus.wreq = 1'b1; bus.wwe = 1'b1; bus.wadr = 15'h0200; bus.wdin = 32'h12345678;
        mid();
        check("wbw_we", {31'd0, bus.sram_we}, 32'd1);
        check("wbw_adr", 32'(bus.sram_adr), 32'h0200);
        check("wbw_dout", bus.sram_dout, 32'h12345678);
        check("wbw_wack0", {31'd0, bus.wack}, 32'd0);
        cyc();
        mid();
        check("wbw_wack1", {31'd0, bus.wack}, 32'd1);
        check("wbw_no_2nd", {31'd0, bus.sram_we}, 32'd0);
        cyc();
        bus.wreq = 1'b0; bus.wwe = 1'b0;
        mid();
        check("wbw_wack2", {31'd0, bus.wack}, 32'd0);
        check("wbw_mem", mem[16'h0200], 32'h12345678);

        // Wishbone read
        cyc();
        bus.wreq = 1'b1; bus.wwe = 1'b0;
        mid();
        check("wbr_re", {31'd0, bus.sram_re}, 32'd1);
        check("wbr_wack0", {31'd0, bus.wack}, 32'd0);
        cyc();
        mid();
        check("wbr_wack1", {31'd0, bus.wack}, 32'd1);
        check("wbr_no_2nd", {31'd0, bus.sram_re}, 32'd0);
        cyc();
        bus.wreq = 1'b0;
        mid();
        check("wbr_wdout", bus.wdout, 32'h12345678);
        check("wbr_wack2", {31'd0, bus.wack}, 32'd0);

        // Starvation
        cyc();
        starve("starve");

        // Stray write qualifier
        cyc();
        bus.mreq = 1'b0; bus.mwe = 1'b1; bus.madr = 15'h0010; bus.mdout = 32'hBAD0BAD0;
        for (int i = 0; i < 10; i++) begin
            mid();
            check("stray_we", {31'd0, bus.sram_we}, 32'd0);
            cyc();
        end
        bus.mwe = 1'b0;
        mid();
        check("stray_mem", mem[16], 32'hDEADBEEF);

        // Reset in the WB_ACK cycle
        cyc();
        bus.wreq = 1'b1; bus.wwe = 1'b0; bus.wadr = 15'h0200;
        mid();
        check("mr_re", {31'd0, bus.sram_re}, 32'd1);
        cyc();
        check("mr_wack_pre", {31'd0, bus.wack}, 32'd1);
        #1;
        rst = 1'b0; bus.mreq = 1'b1;
        #1;
        check("mr_wack_drop", {31'd0, bus.wack}, 32'd0);
        check("mr_mack", {31'd0, bus.mack}, 32'd0);
        check("mr_re_off", {31'd0, bus.sram_re}, 32'd0);
        mid();
        cyc();
        mid();
        check("mr_wack_hold", {31'd0, bus.wack}, 32'd0);

        // Build up the wait count, reset, then confirm it restarts from 0
        cyc();
        rst = 1'b1;
        mid();
        cyc();
        mid();
        cyc();
        rst = 1'b0;
        mid();
        cyc();
        rst = 1'b1;
        starve("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
